// File: rtl/pipe_reg_elastic_pkg.sv
// Shared constants and helpers for the elastic pipeline register.
package pipe_reg_elastic_pkg;

    localparam int unsigned DEFAULT_RESET_VALUE = 0;

    // Width needed to hold an occupancy value in 0..depth.
    function automatic int count_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_elastic_stage.sv
// One elastic stage: WIDTH-bit data register plus its valid bit.
module pipe_stage
    import pipe_reg_elastic_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             adv,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             v
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Flush kills the valid bit but leaves the data register untouched.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            data_d  = d;
            valid_d = 1'b1;
        end else if (adv) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            data_q  <= RESET_VALUE;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q = data_q;
    assign v = valid_q;

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: DEPTH valid/ready stages with flush and occupancy count.
module pipe_reg_elastic
    import pipe_reg_elastic_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          d,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          q,
    output logic [count_w(DEPTH)-1:0] count
);

    localparam int CW = count_w(DEPTH);

    logic [DEPTH-1:0] v, rdy, adv, load;
    logic [WIDTH-1:0] data [DEPTH];

    assign out_valid = v[DEPTH-1] && !flush;
    assign in_ready  = rdy[0] && !flush;
    assign q         = data[DEPTH-1];

    // Ready ripples from the output back to the input so a full chain can
    // still accept a word in the same cycle the last stage drains.
    always_comb begin
        adv          = '0;
        rdy          = '0;
        load         = '0;
        adv[DEPTH-1] = v[DEPTH-1] && !flush && out_ready;
        rdy[DEPTH-1] = !v[DEPTH-1] || adv[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k] = v[k] && rdy[k+1];
            rdy[k] = !v[k] || adv[k];
        end
        load[0] = in_valid && rdy[0] && !flush;
        for (int k = 1; k < DEPTH; k++) begin
            load[k] = v[k-1] && rdy[k];
        end
    end

    always_comb begin
        count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count = count + CW'(v[k]);
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] src;
        if (k == 0) begin : g_first
            assign src = d;
        end else begin : g_next
            assign src = data[k-1];
        end

        pipe_stage #(
            .WIDTH      (WIDTH),
            .RESET_VALUE(RESET_VALUE)
        ) u_stage (
            .CLK  (CLK),
            .reset(reset),
            .flush(flush),
            .load (load[k]),
            .adv  (adv[k]),
            .d    (src),
            .q    (data[k]),
            .v    (v[k])
        );
    end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed bench: scoreboard on a DEPTH=3 instance plus a DEPTH=4 bubble-collapse instance.
module tb_pipe_reg_elastic;

    logic       CLK = 1'b0;
    logic       reset, flush, in_valid, out_ready;
    logic [7:0] d;
    logic       in_ready, out_valid;
    logic [7:0] q;
    logic [1:0] count;

    logic       flush4, in_valid4, out_ready4;
    logic [7:0] d4;
    logic       in_ready4, out_valid4;
    logic [7:0] q4;
    logic [2:0] count4;

    logic [7:0] exp_d;
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_pop    = 0;

    always #5 CLK = ~CLK;

    pipe_reg_elastic #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hFC)) dut (
        .CLK(CLK), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .d(d),
        .out_valid(out_valid), .out_ready(out_ready), .q(q), .count(count)
    );

    pipe_reg_elastic #(.WIDTH(8), .DEPTH(4)) dut4 (
        .CLK(CLK), .reset(reset), .flush(flush4),
        .in_valid(in_valid4), .in_ready(in_ready4), .d(d4),
        .out_valid(out_valid4), .out_ready(out_ready4), .q(q4), .count(count4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: push on accepted input, pop and compare on delivered output.
    always @(negedge CLK) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %0h expected none", q);
                end else begin
                    check("sb_data", 32'(q), 32'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(exp_d);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [7:0] strm_d   [8];
    logic [7:0] strm_exp [8];
    logic [7:0] ov_exp;
    logic [7:0] fill_d   [3];

    initial begin
        strm_d   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        strm_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        ov_exp   = 8'h78;
        fill_d   = '{8'h10, 8'h11, 8'h12};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; d = 8'h00; exp_d = 8'h00; out_ready = 1'b0;
        flush4 = 1'b0; in_valid4 = 1'b0; d4 = 8'h00; out_ready4 = 1'b0;
        #1;
        check("rst_q", 32'(q), 32'hFC);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst4_q", 32'(q4), 0);
        check("rst4_count", 32'(count4), 0);
        @(negedge CLK);
        #2 reset = 1'b0;

        // Streaming, out_ready high: first word visible 3 cycles after issue, no gaps.
        tick();
        out_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            in_valid = (t < 4);
            d        = strm_d[t];
            exp_d    = strm_exp[t];
            @(negedge CLK);
            check($sformatf("strm_ov%0d", t), 32'(out_valid), 32'(ov_exp[t]));
            tick();
        end
        in_valid = 1'b0;

        // Fill to full with back-pressure, then pass-through on release.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; d = fill_d[i]; exp_d = fill_d[i];
            @(negedge CLK);
            check($sformatf("fill_rdy%0d", i), 32'(in_ready), 1);
            tick();
        end
        d = 8'h13; exp_d = 8'h13;
        @(negedge CLK);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_count", 32'(count), 3);
        check("full_q", 32'(q), 32'h10);
        check("full_ov", 32'(out_valid), 1);
        tick();
        @(negedge CLK);
        check("frozen_count", 32'(count), 3);
        check("frozen_q", 32'(q), 32'h10);
        tick();
        out_ready = 1'b1;
        @(negedge CLK);
        check("pass_in_ready", 32'(in_ready), 1);
        check("pass_count", 32'(count), 3);
        tick();
        in_valid = 1'b0;
        @(negedge CLK);
        check("pass_count_after", 32'(count), 3);
        check("pass_q", 32'(q), 32'h11);
        repeat (4) @(posedge CLK);
        #1;
        @(negedge CLK);
        check("drain_count", 32'(count), 0);
        check("drain_ov", 32'(out_valid), 0);
        check("drain_q_hold", 32'(q), 32'h13);

        // Flush with two words inside and a word offered in the flush cycle.
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; d = 8'h20; exp_d = 8'h20;
        tick();
        d = 8'h21; exp_d = 8'h21;
        tick();
        in_valid = 1'b0;
        tick();
        @(negedge CLK);
        check("pre_fl_count", 32'(count), 2);
        check("pre_fl_ov", 32'(out_valid), 1);
        tick();
        flush = 1'b1; in_valid = 1'b1; d = 8'h22; exp_d = 8'h22;
        @(negedge CLK);
        check("fl_in_ready", 32'(in_ready), 0);
        check("fl_ov", 32'(out_valid), 0);
        check("fl_count", 32'(count), 2);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        check("post_fl_count", 32'(count), 0);
        check("post_fl_ov", 32'(out_valid), 0);
        check("post_fl_q_hold", 32'(q), 32'h20);
        tick();
        out_ready = 1'b1;
        in_valid = 1'b1; d = 8'h30; exp_d = 8'h30;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();

        // Asynchronous reset while words are in flight, released off-edge.
        in_valid = 1'b1; d = 8'h40; exp_d = 8'h40;
        tick();
        d = 8'h41; exp_d = 8'h41;
        tick();
        d = 8'h42; exp_d = 8'h42;
        #2;
        check("mid_count", 32'(count), 2);
        reset = 1'b1; in_valid = 1'b0;
        exp_q.delete();
        #1;
        check("rst2_count", 32'(count), 0);
        check("rst2_ov", 32'(out_valid), 0);
        check("rst2_q", 32'(q), 32'hFC);
        check("rst2_in_ready", 32'(in_ready), 1);
        @(posedge CLK);
        @(negedge CLK);
        #2 reset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; d = 8'(8'h50 + i); exp_d = 8'(8'h50 + i);
            tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();
        check("sb_empty", 32'(exp_q.size()), 0);
        check("sb_pops", 32'(n_pop), 12);

        // Bubble collapse on the DEPTH=4 instance.
        in_valid4 = 1'b1; d4 = 8'h0A;
        tick();
        in_valid4 = 1'b0;
        tick();
        in_valid4 = 1'b1; d4 = 8'h0B;
        tick();
        in_valid4 = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        check("bub_count", 32'(count4), 2);
        check("bub_q", 32'(q4), 32'h0A);
        check("bub_ov", 32'(out_valid4), 1);
        check("bub_in_ready", 32'(in_ready4), 1);
        tick();
        out_ready4 = 1'b1;
        @(negedge CLK);
        check("bub_out_q", 32'(q4), 32'h0A);
        tick();
        @(negedge CLK);
        check("bub_q2", 32'(q4), 32'h0B);
        check("bub_count2", 32'(count4), 1);
        tick();
        @(negedge CLK);
        check("bub_count3", 32'(count4), 0);
        check("bub_q3_hold", 32'(q4), 32'h0B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
